// File: rtl/spiifc.sv
// SPI mode-0 slave bridging an external master to rx/tx block RAMs; optional SPIIFC_DEBUG_EN status word.
// Latency: 2-FF sync + edge register, so pin activity is acted on 2-3 SysClk later.
// No backpressure: rx writes are 1-cycle pulses, and the tx word is fetched one cycle before the next reload.
module spiifc #(
   parameter int WORD_W = 16,
   parameter int ADDR_W = 12
) (
   input  logic              SysClk,
   input  logic              Reset,
   input  logic              SPI_CLK,
   input  logic              SPI_MOSI,
   input  logic              SPI_SS,
   output logic              SPI_MISO,
   output logic [ADDR_W-1:0] txMemAddr,
   input  logic [WORD_W-1:0] txMemData,
   output logic [ADDR_W-1:0] rcMemAddr,
   output logic [WORD_W-1:0] rcMemData,
   output logic              rcMemWE,
   output logic [15:0]       debug_out
);

   localparam int CNT_W = $clog2(WORD_W);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 1);

   // [0],[1] form the synchronizer; [2] is the delayed copy for edge detection
   logic [2:0] sclk_q, ss_q;
   logic [1:0] mosi_q;

   logic              active_q, active_d;
   logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
   logic [WORD_W-1:0] rx_sr_q, rx_sr_d;
   logic [WORD_W-1:0] rc_data_q, rc_data_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] rc_addr_q, rc_addr_d;
   logic [ADDR_W-1:0] tx_addr_q, tx_addr_d;
   logic [WORD_W-1:0] tx_sr_q, tx_sr_d;
   logic [1:0]        ld_q, ld_d;
   logic              reload_q, reload_d;

   logic sclk_rise, sclk_fall, ss_fall, ss_rise;

   assign sclk_rise = sclk_q[1] & ~sclk_q[2];
   assign sclk_fall = ~sclk_q[1] & sclk_q[2];
   assign ss_fall   = ~ss_q[1] & ss_q[2];
   assign ss_rise   = ss_q[1] & ~ss_q[2];

   always_comb begin
      active_d  = active_q;
      bit_cnt_d = bit_cnt_q;
      rx_sr_d   = rx_sr_q;
      rc_data_d = rc_data_q;
      we_d      = 1'b0;
      rc_addr_d = rc_addr_q;
      tx_addr_d = tx_addr_q;
      tx_sr_d   = tx_sr_q;
      ld_d      = {ld_q[0], 1'b0};
      reload_d  = reload_q;

      if (we_q)
         rc_addr_d = rc_addr_q + 1'b1;

      // active_q arms only on a real SS fall, so a reset released with SS low stays idle
      if (ss_fall) begin
         active_d  = 1'b1;
         bit_cnt_d = '0;
         rx_sr_d   = '0;
         rc_addr_d = '0;
         tx_addr_d = '0;
         ld_d[0]   = 1'b1;
         reload_d  = 1'b0;
      end else if (ss_rise) begin
         active_d  = 1'b0;
         bit_cnt_d = '0;
         reload_d  = 1'b0;
      end else if (active_q) begin
         if (sclk_rise) begin
            rx_sr_d = {rx_sr_q[WORD_W-2:0], mosi_q[1]};
            if (bit_cnt_q == LAST_BIT) begin
               bit_cnt_d = '0;
               rc_data_d = rx_sr_d;
               we_d      = 1'b1;
               tx_addr_d = tx_addr_q + 1'b1;
               reload_d  = 1'b1;
            end else begin
               bit_cnt_d = bit_cnt_q + 1'b1;
            end
         end else if (sclk_fall) begin
            if (reload_q) begin
               tx_sr_d  = txMemData;
               reload_d = 1'b0;
            end else begin
               tx_sr_d = {tx_sr_q[WORD_W-2:0], 1'b0};
            end
         end
      end

      if (ld_q[1])
         tx_sr_d = txMemData;
   end

   always_ff @(posedge SysClk or negedge Reset) begin
      if (!Reset) begin
         sclk_q    <= '0;
         ss_q      <= '0;
         mosi_q    <= '0;
         active_q  <= 1'b0;
         bit_cnt_q <= '0;
         rx_sr_q   <= '0;
         rc_data_q <= '0;
         we_q      <= 1'b0;
         rc_addr_q <= '0;
         tx_addr_q <= '0;
         tx_sr_q   <= '0;
         ld_q      <= '0;
         reload_q  <= 1'b0;
      end else begin
         sclk_q    <= {sclk_q[1:0], SPI_CLK};
         ss_q      <= {ss_q[1:0], SPI_SS};
         mosi_q    <= {mosi_q[0], SPI_MOSI};
         active_q  <= active_d;
         bit_cnt_q <= bit_cnt_d;
         rx_sr_q   <= rx_sr_d;
         rc_data_q <= rc_data_d;
         we_q      <= we_d;
         rc_addr_q <= rc_addr_d;
         tx_addr_q <= tx_addr_d;
         tx_sr_q   <= tx_sr_d;
         ld_q      <= ld_d;
         reload_q  <= reload_d;
      end
   end

   assign SPI_MISO  = active_q & tx_sr_q[WORD_W-1];
   assign txMemAddr = tx_addr_q;
   assign rcMemAddr = rc_addr_q;
   assign rcMemData = rc_data_q;
   assign rcMemWE   = we_q;

`ifdef SPIIFC_DEBUG_EN
   logic [7:0] wcnt_q;

   always_ff @(posedge SysClk or negedge Reset) begin
      if (!Reset)
         wcnt_q <= '0;
      else if (ss_fall)
         wcnt_q <= '0;
      else if (we_q)
         wcnt_q <= wcnt_q + 1'b1;
   end

   assign debug_out = {wcnt_q, 3'b000, ss_q[1], 4'(bit_cnt_q)};
`else
   assign debug_out = 16'h0000;
`endif

endmodule

// File: tb/tb_spiifc.sv
// Directed bench for spiifc: SPI master model at 20 MHz against a 100 MHz SysClk,
// 1-cycle tx memory model and an rx write monitor. Address width reduced so wrap is reachable.
module tb_spiifc;

   localparam int AW = 4;

   logic          SysClk = 1'b0;
   logic          Reset;
   logic          SPI_CLK;
   logic          SPI_MOSI;
   logic          SPI_SS;
   logic          SPI_MISO;
   logic [AW-1:0] txMemAddr;
   logic [15:0]   txMemData;
   logic [AW-1:0] rcMemAddr;
   logic [15:0]   rcMemData;
   logic          rcMemWE;
   logic [15:0]   debug_out;

   spiifc #(.WORD_W(16), .ADDR_W(AW)) dut (
      .SysClk    (SysClk),
      .Reset     (Reset),
      .SPI_CLK   (SPI_CLK),
      .SPI_MOSI  (SPI_MOSI),
      .SPI_SS    (SPI_SS),
      .SPI_MISO  (SPI_MISO),
      .txMemAddr (txMemAddr),
      .txMemData (txMemData),
      .rcMemAddr (rcMemAddr),
      .rcMemData (rcMemData),
      .rcMemWE   (rcMemWE),
      .debug_out (debug_out)
   );

   always #5 SysClk = ~SysClk;

   logic [15:0] txmem [0:(1<<AW)-1];
   always @(posedge SysClk) txMemData <= txmem[txMemAddr];

   logic [AW-1:0] wr_addr [$];
   logic [15:0]   wr_data [$];
   int            we_wide = 0;
   logic          we_prev = 1'b0;

   always @(negedge SysClk) begin
      if (rcMemWE === 1'b1) begin
         wr_addr.push_back(rcMemAddr);
         wr_data.push_back(rcMemData);
         if (we_prev) we_wide++;
      end
      we_prev <= (rcMemWE === 1'b1);
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Entered and left 1 ns before a SysClk rise with SPI_CLK low; MOSI changes mid-low-phase.
   task automatic spi_bits(input logic [15:0] dout, input int n, output logic [15:0] din);
      din = '0;
      for (int i = 0; i < n; i++) begin
         #12 SPI_MOSI = dout[15-i];
         #13 SPI_CLK = 1'b1;
         din = {din[14:0], SPI_MISO};
         #25 SPI_CLK = 1'b0;
      end
   endtask

   task automatic clear_log();
      wr_addr.delete();
      wr_data.delete();
      we_wide = 0;
   endtask

   logic [15:0] rd;

   initial begin
      Reset    = 1'b0;
      SPI_CLK  = 1'b0;
      SPI_MOSI = 1'b0;
      SPI_SS   = 1'b1;
      for (int k = 0; k < (1<<AW); k++) txmem[k] = 16'h0000;
      txmem[0] = 16'hBEEF;
      txmem[1] = 16'h0F0F;

      // reset state
      repeat (3) @(posedge SysClk);
      @(negedge SysClk);
      chk("rst_miso",   32'(SPI_MISO),  32'h0);
      chk("rst_txaddr", 32'(txMemAddr), 32'h0);
      chk("rst_rcaddr", 32'(rcMemAddr), 32'h0);
      chk("rst_rcdata", 32'(rcMemData), 32'h0);
      chk("rst_we",     32'(rcMemWE),   32'h0);
      chk("rst_debug",  32'(debug_out), 32'h0);
      Reset = 1'b1;
      @(posedge SysClk);
      #9;

      // clocks with SS high are ignored
      spi_bits(16'hFFFF, 16, rd);
      #20;
      chk("idle_writes", 32'(wr_addr.size()), 32'd0);
      chk("idle_miso",   32'(rd),             32'h0);

      // two words in, two words out
      clear_log();
      SPI_SS = 1'b0;
      #100;
      chk("tx_addr0", 32'(txMemAddr), 32'd0);
      spi_bits(16'hA5C3, 16, rd);
      #20;
      chk("miso_w0",  32'(rd),        32'hBEEF);
      chk("tx_addr1", 32'(txMemAddr), 32'd1);
      chk("rc_addr1", 32'(rcMemAddr), 32'd1);
      spi_bits(16'h1234, 16, rd);
      #20;
      chk("miso_w1",  32'(rd),        32'h0F0F);
      chk("tx_addr2", 32'(txMemAddr), 32'd2);
      chk("rc_addr2", 32'(rcMemAddr), 32'd2);
      SPI_SS = 1'b1;
      #100;
      chk("two_cnt",   32'(wr_addr.size()), 32'd2);
      chk("two_a0",    32'(wr_addr[0]),     32'd0);
      chk("two_d0",    32'(wr_data[0]),     32'hA5C3);
      chk("two_a1",    32'(wr_addr[1]),     32'd1);
      chk("two_d1",    32'(wr_data[1]),     32'h1234);
      chk("we_width",  32'(we_wide),        32'd0);
      chk("miso_ss_hi", 32'(SPI_MISO),      32'h0);
      chk("hold_data", 32'(rcMemData),      32'h1234);

      // partial word is discarded
      clear_log();
      SPI_SS = 1'b0;
      #100;
      spi_bits(16'hFFFF, 9, rd);
      #20;
      SPI_SS = 1'b1;
      #100;
      SPI_SS = 1'b0;
      #100;
      spi_bits(16'h00FF, 16, rd);
      #20;
      SPI_SS = 1'b1;
      #100;
      chk("part_cnt", 32'(wr_addr.size()), 32'd1);
      chk("part_a",   32'(wr_addr[0]),     32'd0);
      chk("part_d",   32'(wr_data[0]),     32'h00FF);

      // address wrap
      clear_log();
      SPI_SS = 1'b0;
      #100;
      for (int k = 0; k < (1<<AW); k++) spi_bits(16'h1000 + 16'(k), 16, rd);
      spi_bits(16'hCAFE, 16, rd);
      #20;
      chk("wrap_cnt",    32'(wr_addr.size()),        32'd17);
      chk("wrap_last_a", 32'(wr_addr[(1<<AW)-1]),    32'((1<<AW)-1));
      chk("wrap_last_d", 32'(wr_data[(1<<AW)-1]),    32'h100F);
      chk("wrap_a",      32'(wr_addr[1<<AW]),        32'd0);
      chk("wrap_d",      32'(wr_data[1<<AW]),        32'hCAFE);
      chk("wrap_txaddr", 32'(txMemAddr),             32'd1);
      SPI_SS = 1'b1;
      #100;

      // reset mid-transfer, then a fresh transfer
      clear_log();
      SPI_SS = 1'b0;
      #100;
      spi_bits(16'hFFFF, 8, rd);
      Reset = 1'b0;
      #30;
      chk("mid_rst_rcaddr", 32'(rcMemAddr), 32'h0);
      chk("mid_rst_txaddr", 32'(txMemAddr), 32'h0);
      chk("mid_rst_miso",   32'(SPI_MISO),  32'h0);
      Reset = 1'b1;
      #50;
      spi_bits(16'hFFFF, 8, rd);
      #20;
      chk("post_rst_idle", 32'(wr_addr.size()), 32'd0);
      SPI_SS = 1'b1;
      #100;
      SPI_SS = 1'b0;
      #100;
      spi_bits(16'h3C5A, 16, rd);
      #20;
      SPI_SS = 1'b1;
      #100;
      chk("rst_cnt", 32'(wr_addr.size()), 32'd1);
      chk("rst_a",   32'(wr_addr[0]),     32'd0);
      chk("rst_d",   32'(wr_data[0]),     32'h3C5A);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
